// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// The ALU decoder imports the ALUOp codes from here as well.
package multicycle_ctrl_fsm_pkg;

  // Opcodes as they appear in IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       Op;
  logic             MemReady;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             Branch;
  logic             BranchNe;
  logic             RegDst;
  logic             MemToReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             ZeroExt;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUOp;
  logic             IllegalOp;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, MemReady,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNe,
           RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSrc,
           ALUOp, IllegalOp, InstrCount
  );

  modport slave (
    output Op, MemReady,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNe,
           RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ZeroExt, PCSrc,
           ALUOp, IllegalOp, InstrCount
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences each instruction and drives the
// datapath muxes/enables as Moore decodes of the state.
//
// state    | meaning
// ---------+-----------------------------------------------
// FETCH    | read instruction, PC+4; waits for MemReady
// DECODE   | capture Op, precompute branch target
// MEMADR   | base + offset for LW/SW
// MEMRD    | data read; waits for MemReady
// MEMWB    | MDR -> rt
// MEMWR    | data write; waits for MemReady
// EXEC     | R-type ALU operation
// ALUWB    | ALUOut -> rd
// BRANCH   | compare rs/rt, conditional PC load
// IEXEC    | immediate ALU operation
// IWB      | ALUOut -> rt
// JUMP     | PC <- jump target
// TRAP     | illegal opcode, one-cycle IllegalOp, no retire
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter bit EXT_OPS     = 1'b1,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  state_e           state, state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] instr_cnt;
  logic             mem_rdy, retire;
  logic             mem_read, mem_write, ir_write, pc_write, reg_write;
  logic             iord, branch, branch_ne, reg_dst, mem_to_reg;
  logic             alu_src_a, zero_ext, illegal;
  logic [1:0]       alu_src_b, pc_src;
  logic [2:0]       alu_op;

  assign mem_rdy = MEM_WAIT_EN ? bus.MemReady : 1'b1;

  // State register; reset discards any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Opcode is frozen in DECODE so later IR/Op activity cannot redirect the path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 op_q <= OP_RTYPE;
    else if (state == S_DECODE) op_q <= bus.Op;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt  = S_FETCH;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    zero_ext   = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
        state_nxt = mem_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BR;
        state_nxt = S_TRAP;
        case (bus.Op)
          OP_RTYPE:                 state_nxt = S_EXEC;
          OP_LW, OP_SW:             state_nxt = S_MEMADR;
          OP_BEQ:                   state_nxt = S_BRANCH;
          OP_ADDI:                  state_nxt = S_IEXEC;
          OP_J:                     state_nxt = S_JUMP;
          OP_BNE:                   if (EXT_OPS) state_nxt = S_BRANCH;
          OP_ANDI, OP_ORI, OP_SLTI: if (EXT_OPS) state_nxt = S_IEXEC;
          default: ;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read  = 1'b1;
        iord      = 1'b1;
        state_nxt = mem_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_rdy;
        state_nxt = mem_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = (op_q == OP_BEQ);
        branch_ne = (op_q == OP_BNE);
        retire    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = S_IWB;
        case (op_q)
          OP_ANDI: begin alu_op = ALU_AND; zero_ext = 1'b1; end
          OP_ORI:  begin alu_op = ALU_OR;  zero_ext = 1'b1; end
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  // Strobes are held low for the whole reset assertion, not just after it
  assign bus.MemRead    = rst_n & mem_read;
  assign bus.MemWrite   = rst_n & mem_write;
  assign bus.IRWrite    = rst_n & ir_write;
  assign bus.PCWrite    = rst_n & pc_write;
  assign bus.RegWrite   = rst_n & reg_write;
  assign bus.IorD       = iord;
  assign bus.Branch     = branch;
  assign bus.BranchNe   = branch_ne;
  assign bus.RegDst     = reg_dst;
  assign bus.MemToReg   = mem_to_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ZeroExt    = zero_ext;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUOp      = alu_op;
  assign bus.IllegalOp  = illegal;
  assign bus.InstrCount = instr_cnt;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: default build, EXT_OPS=0 build,
// and MEM_WAIT_EN=0 / CNT_W=4 build, exercised one at a time.
module tb_multicycle_ctrl_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, JMP = 6'b000010, BAD = 6'b111111;

  // Control vector bit positions (MSB..LSB):
  // MemRead MemWrite IorD IRWrite PCWrite Branch BranchNe RegDst MemToReg
  // RegWrite ALUSrcA ALUSrcB[1:0] ZeroExt PCSrc[1:0] ALUOp[2:0] IllegalOp
  localparam logic [19:0] MR   = 20'd1 << 19, MW  = 20'd1 << 18, IORD = 20'd1 << 17;
  localparam logic [19:0] IRW  = 20'd1 << 16, PCW = 20'd1 << 15, BR   = 20'd1 << 14;
  localparam logic [19:0] BRNE = 20'd1 << 13, RD  = 20'd1 << 12, M2R  = 20'd1 << 11;
  localparam logic [19:0] RW   = 20'd1 << 10, SA  = 20'd1 << 9,  ZE   = 20'd1 << 6;
  localparam logic [19:0] SB_FOUR = 20'd1 << 7, SB_IMM = 20'd2 << 7, SB_BR = 20'd3 << 7;
  localparam logic [19:0] PCS_AO = 20'd1 << 4, PCS_J = 20'd2 << 4;
  localparam logic [19:0] A_SUB = 20'd1 << 1, A_FN = 20'd2 << 1, A_AND = 20'd3 << 1;
  localparam logic [19:0] ILL = 20'd1;

  localparam logic [19:0] V_RST  = SB_FOUR;
  localparam logic [19:0] V_FW   = MR | SB_FOUR;
  localparam logic [19:0] V_FR   = MR | IRW | PCW | SB_FOUR;
  localparam logic [19:0] V_DEC  = SB_BR;
  localparam logic [19:0] V_MADR = SA | SB_IMM;
  localparam logic [19:0] V_MRD  = MR | IORD;
  localparam logic [19:0] V_MWB  = M2R | RW;
  localparam logic [19:0] V_MWR  = MW | IORD;
  localparam logic [19:0] V_EXEC = SA | A_FN;
  localparam logic [19:0] V_AWB  = RD | RW;
  localparam logic [19:0] V_BEQ  = BR | SA | PCS_AO | A_SUB;
  localparam logic [19:0] V_BNE  = BRNE | SA | PCS_AO | A_SUB;
  localparam logic [19:0] V_IADD = SA | SB_IMM;
  localparam logic [19:0] V_IAND = SA | SB_IMM | ZE | A_AND;
  localparam logic [19:0] V_IWB  = RW;
  localparam logic [19:0] V_JMP  = PCW | PCS_J;
  localparam logic [19:0] V_TRAP = ILL;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic [5:0] op_drv = 6'd0;
  logic       rdy_drv = 1'b0;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.CNT_W(32)) if0 ();
  multicycle_ctrl_fsm_if #(.CNT_W(32)) if1 ();
  multicycle_ctrl_fsm_if #(.CNT_W(4))  if2 ();

  assign if0.Op = op_drv;  assign if0.MemReady = rdy_drv;
  assign if1.Op = op_drv;  assign if1.MemReady = rdy_drv;
  assign if2.Op = op_drv;  assign if2.MemReady = rdy_drv;

  multicycle_ctrl_fsm #(.EXT_OPS(1'b1), .MEM_WAIT_EN(1'b1), .CNT_W(32))
    u0 (.clk(clk), .rst_n(rst0), .bus(if0));
  multicycle_ctrl_fsm #(.EXT_OPS(1'b0), .MEM_WAIT_EN(1'b1), .CNT_W(32))
    u1 (.clk(clk), .rst_n(rst1), .bus(if1));
  multicycle_ctrl_fsm #(.EXT_OPS(1'b1), .MEM_WAIT_EN(1'b0), .CNT_W(4))
    u2 (.clk(clk), .rst_n(rst2), .bus(if2));

  logic [19:0] v0, v1, v2;
  assign v0 = {if0.MemRead, if0.MemWrite, if0.IorD, if0.IRWrite, if0.PCWrite,
               if0.Branch, if0.BranchNe, if0.RegDst, if0.MemToReg, if0.RegWrite,
               if0.ALUSrcA, if0.ALUSrcB, if0.ZeroExt, if0.PCSrc, if0.ALUOp, if0.IllegalOp};
  assign v1 = {if1.MemRead, if1.MemWrite, if1.IorD, if1.IRWrite, if1.PCWrite,
               if1.Branch, if1.BranchNe, if1.RegDst, if1.MemToReg, if1.RegWrite,
               if1.ALUSrcA, if1.ALUSrcB, if1.ZeroExt, if1.PCSrc, if1.ALUOp, if1.IllegalOp};
  assign v2 = {if2.MemRead, if2.MemWrite, if2.IorD, if2.IRWrite, if2.PCWrite,
               if2.Branch, if2.BranchNe, if2.RegDst, if2.MemToReg, if2.RegWrite,
               if2.ALUSrcA, if2.ALUSrcB, if2.ZeroExt, if2.PCSrc, if2.ALUOp, if2.IllegalOp};

  function automatic logic [19:0] vec_of(input int sel);
    return (sel == 0) ? v0 : (sel == 1) ? v1 : v2;
  endfunction

  function automatic logic [31:0] cnt_of(input int sel);
    return (sel == 0) ? if0.InstrCount : (sel == 1) ? if1.InstrCount : {28'd0, if2.InstrCount};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the control vector mid-cycle, advance
  task automatic cyc(input int sel, input logic [5:0] op, input logic rdy,
                     input logic [19:0] exp, input string tag);
    op_drv  = op;
    rdy_drv = rdy;
    @(negedge clk);
    chk(tag, {12'd0, vec_of(sel)}, {12'd0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state: strobes low even with MemReady high, FETCH mux values
    rdy_drv = 1'b1;
    #1;
    chk("rst_vec", {12'd0, v0}, {12'd0, V_RST});
    chk("rst_cnt", cnt_of(0), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b1;

    // LW, SW, RTYPE, ADDI, BEQ, J back to back, no wait states
    cyc(0, LW, 1, V_FR,   "lw_fetch");  cyc(0, LW, 1, V_DEC, "lw_dec");
    cyc(0, LW, 1, V_MADR, "lw_madr");   cyc(0, LW, 1, V_MRD, "lw_mrd");
    cyc(0, LW, 1, V_MWB,  "lw_mwb");
    cyc(0, SW, 1, V_FR,   "sw_fetch");  cyc(0, SW, 1, V_DEC, "sw_dec");
    cyc(0, SW, 1, V_MADR, "sw_madr");   cyc(0, SW, 1, V_MWR, "sw_mwr");
    cyc(0, RT, 1, V_FR,   "rt_fetch");  cyc(0, RT, 1, V_DEC, "rt_dec");
    cyc(0, RT, 1, V_EXEC, "rt_exec");   cyc(0, RT, 1, V_AWB, "rt_awb");
    cyc(0, ADDI, 1, V_FR, "ad_fetch");  cyc(0, ADDI, 1, V_DEC, "ad_dec");
    cyc(0, ADDI, 1, V_IADD, "ad_iexec"); cyc(0, ADDI, 1, V_IWB, "ad_iwb");
    cyc(0, BEQ, 1, V_FR,  "beq_fetch"); cyc(0, BEQ, 1, V_DEC, "beq_dec");
    cyc(0, BEQ, 1, V_BEQ, "beq_br");
    cyc(0, JMP, 1, V_FR,  "j_fetch");   cyc(0, JMP, 1, V_DEC, "j_dec");
    cyc(0, JMP, 1, V_JMP, "j_jump");
    chk("seq_cnt", cnt_of(0), 32'd6);

    // LW with three wait cycles in MEMRD, then a FETCH wait cycle
    cyc(0, LW, 1, V_FR,   "lww_fetch"); cyc(0, LW, 1, V_DEC, "lww_dec");
    cyc(0, LW, 1, V_MADR, "lww_madr");
    for (int i = 0; i < 3; i++) cyc(0, LW, 0, V_MRD, "lww_mrd_wait");
    cyc(0, LW, 1, V_MRD,  "lww_mrd_go"); cyc(0, LW, 1, V_MWB, "lww_mwb");
    cyc(0, LW, 0, V_FW,   "fetch_wait");
    chk("lww_cnt", cnt_of(0), 32'd7);

    // Extended ops: ANDI and BNE
    cyc(0, ANDI, 1, V_FR, "andi_fetch"); cyc(0, ANDI, 1, V_DEC, "andi_dec");
    cyc(0, ANDI, 1, V_IAND, "andi_iexec"); cyc(0, ANDI, 1, V_IWB, "andi_iwb");
    cyc(0, BNE, 1, V_FR,  "bne_fetch"); cyc(0, BNE, 1, V_DEC, "bne_dec");
    cyc(0, BNE, 1, V_BNE, "bne_br");
    chk("ext_cnt", cnt_of(0), 32'd9);

    // Illegal opcode: TRAP then FETCH, no retire
    cyc(0, BAD, 1, V_FR,  "bad_fetch"); cyc(0, BAD, 1, V_DEC, "bad_dec");
    cyc(0, BAD, 1, V_TRAP, "bad_trap"); cyc(0, BAD, 0, V_FW, "bad_refetch");
    chk("trap_cnt", cnt_of(0), 32'd9);

    // Op changes after DECODE must not alter the path
    cyc(0, RT, 1, V_FR,   "tog_fetch"); cyc(0, RT, 1, V_DEC, "tog_dec");
    cyc(0, LW, 1, V_EXEC, "tog_exec");  cyc(0, BAD, 1, V_AWB, "tog_awb");
    cyc(0, ADDI, 1, V_FR, "tog2_fetch"); cyc(0, ADDI, 1, V_DEC, "tog2_dec");
    cyc(0, ANDI, 1, V_IADD, "tog2_iexec"); cyc(0, SW, 1, V_IWB, "tog2_iwb");
    chk("tog_cnt", cnt_of(0), 32'd11);

    // Reset asserted while stalled in MEMRD
    cyc(0, LW, 1, V_FR,   "rlw_fetch"); cyc(0, LW, 1, V_DEC, "rlw_dec");
    cyc(0, LW, 1, V_MADR, "rlw_madr");  cyc(0, LW, 0, V_MRD, "rlw_mrd");
    rdy_drv = 1'b1;
    rst0 = 1'b0;
    #1;
    chk("midrst_vec", {12'd0, v0}, {12'd0, V_RST});
    chk("midrst_cnt", cnt_of(0), 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b1;
    cyc(0, JMP, 1, V_FR,  "post_fetch"); cyc(0, JMP, 1, V_DEC, "post_dec");
    cyc(0, JMP, 1, V_JMP, "post_jump");
    chk("post_cnt", cnt_of(0), 32'd1);
    rst0 = 1'b0;

    // EXT_OPS=0: ANDI and BNE trap, ADDI still decodes
    rst1 = 1'b1;
    cyc(1, ANDI, 1, V_FR, "x_andi_fetch"); cyc(1, ANDI, 1, V_DEC, "x_andi_dec");
    cyc(1, ANDI, 1, V_TRAP, "x_andi_trap"); cyc(1, ANDI, 0, V_FW, "x_andi_refetch");
    cyc(1, BNE, 1, V_FR,  "x_bne_fetch");   cyc(1, BNE, 1, V_DEC, "x_bne_dec");
    cyc(1, BNE, 1, V_TRAP, "x_bne_trap");
    chk("x_trap_cnt", cnt_of(1), 32'd0);
    cyc(1, ADDI, 1, V_FR, "x_ad_fetch");    cyc(1, ADDI, 1, V_DEC, "x_ad_dec");
    cyc(1, ADDI, 1, V_IADD, "x_ad_iexec");  cyc(1, ADDI, 1, V_IWB, "x_ad_iwb");
    chk("x_ad_cnt", cnt_of(1), 32'd1);
    rst1 = 1'b0;

    // MEM_WAIT_EN=0, CNT_W=4: MemReady ignored, counter wraps after 16 retires
    rst2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(2, JMP, 0, V_FR,  "w_j_fetch");
      cyc(2, JMP, 0, V_DEC, "w_j_dec");
      cyc(2, JMP, 0, V_JMP, "w_j_jump");
      if (i == 14) chk("w_cnt15", cnt_of(2), 32'd15);
    end
    chk("w_cnt_wrap", cnt_of(2), 32'd0);
    cyc(2, LW, 0, V_FR,   "w_lw_fetch"); cyc(2, LW, 0, V_DEC, "w_lw_dec");
    cyc(2, LW, 0, V_MADR, "w_lw_madr");  cyc(2, LW, 0, V_MRD, "w_lw_mrd");
    cyc(2, LW, 0, V_MWB,  "w_lw_mwb");
    cyc(2, SW, 0, V_FR,   "w_sw_fetch"); cyc(2, SW, 0, V_DEC, "w_sw_dec");
    cyc(2, SW, 0, V_MADR, "w_sw_madr");  cyc(2, SW, 0, V_MWR, "w_sw_mwr");
    chk("w_mem_cnt", cnt_of(2), 32'd2);
    rst2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
